traffic_phase_controller: RTL and testbench

- Sequences one PIFO test run: alternates enqueue (generate) windows and dequeue windows for a configured number of phases, then drains the PIFO to empty and reports done.
- Sits between the testbench top and the traffic generator / PIFO pair. Drives the generator's generate-phase and phase-count inputs and the PIFO dequeue request.
- Counts enqueues and dequeues for the scoreboard.

---
 rtl/traffic_phase_controller.sv | 211 +++++++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller
//   Sequences one PIFO test run. It alternates generate (GEN) windows and
//   dequeue (DEQ) windows for a configured number of phases. It then drains
//   the PIFO until it is empty and reports done. It also counts enqueues and
//   dequeues for the scoreboard.
//
//   Optional feature macro: TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
//     When defined, DRAIN aborts to DONE after DRAIN_TIMEOUT cycles and sets
//     the sticky o__timeout flag. When not defined, DRAIN waits indefinitely
//     and o__timeout is held at 0.
//
// Ports
//   clk, reset_n        clock and asynchronous active-low reset
//   i__start            start pulse, accepted only in IDLE or DONE
//   i__num_phases       number of GEN+DEQ phase pairs (latched on start)
//   i__gen_cycles       cycles per GEN window (latched on start)
//   i__deq_cycles       cycles per DEQ window (latched on start)
//   i__pifo_empty       PIFO holds no entries
//   i__pkt_enq_valid    generator enqueued a packet this cycle
//   o__generate_phase   high while in GEN
//   o__phase_count      current phase index; holds num_phases in DRAIN/DONE
//   o__pifo_deq_req     dequeue request (DEQ/DRAIN and PIFO not empty)
//   o__busy             not IDLE and not DONE
//   o__done             high in DONE
//   o__timeout          drain aborted (optional feature)
//   o__num_enq          saturating enqueue count for this run
//   o__num_deq          saturating dequeue count for this run
module traffic_phase_controller #(
  parameter int unsigned COUNT_W       = 32,
  parameter int unsigned DRAIN_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i__start,
  input  logic [COUNT_W-1:0] i__num_phases,
  input  logic [COUNT_W-1:0] i__gen_cycles,
  input  logic [COUNT_W-1:0] i__deq_cycles,
  input  logic               i__pifo_empty,
  input  logic               i__pkt_enq_valid,
  output logic               o__generate_phase,
  output logic [COUNT_W-1:0] o__phase_count,
  output logic               o__pifo_deq_req,
  output logic               o__busy,
  output logic               o__done,
  output logic               o__timeout,
  output logic [COUNT_W-1:0] o__num_enq,
  output logic [COUNT_W-1:0] o__num_deq
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_DEQ   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   phase_q, phase_d;
  logic [COUNT_W-1:0]   cyc_q, cyc_d;
  logic [COUNT_W-1:0]   num_phases_q, num_phases_d;
  logic [COUNT_W-1:0]   gen_cycles_q, gen_cycles_d;
  logic [COUNT_W-1:0]   deq_cycles_q, deq_cycles_d;
  logic [COUNT_W-1:0]   num_enq_q, num_enq_d;
  logic [COUNT_W-1:0]   num_deq_q, num_deq_d;
  logic                 generate_phase_q, generate_phase_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 deq_req_c;
  logic [COUNT_W-1:0]   phase_inc_c;
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
  logic                 timeout_q, timeout_d;
`else
  logic                 unused_drain_timeout;
  assign unused_drain_timeout = ^DRAIN_TIMEOUT;
`endif

  // The dequeue request follows the live empty flag, so an empty PIFO is never asked.
  assign deq_req_c   = ((state_q == S_DEQ) || (state_q == S_DRAIN)) && !i__pifo_empty;
  assign phase_inc_c = phase_q + COUNT_W'(1);

  // Next-state, counter and config-latch logic.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cyc_d        = cyc_q;
    num_phases_d = num_phases_q;
    gen_cycles_d = gen_cycles_q;
    deq_cycles_d = deq_cycles_q;
    num_enq_d    = num_enq_q;
    num_deq_d    = num_deq_q;
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
    timeout_d    = timeout_q;
`endif

    if (i__pkt_enq_valid && !(&num_enq_q)) num_enq_d = num_enq_q + COUNT_W'(1);
    if (deq_req_c && !(&num_deq_q))        num_deq_d = num_deq_q + COUNT_W'(1);
    if ((state_q == S_GEN) || (state_q == S_DEQ) || (state_q == S_DRAIN))
      cyc_d = cyc_q + COUNT_W'(1);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i__start) begin
          // The clear overrides any enqueue counted in the same cycle.
          num_phases_d = i__num_phases;
          gen_cycles_d = i__gen_cycles;
          deq_cycles_d = i__deq_cycles;
          num_enq_d    = '0;
          num_deq_d    = '0;
          phase_d      = '0;
          cyc_d        = '0;
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
          timeout_d    = 1'b0;
`endif
          if (i__num_phases == '0)      state_d = S_DRAIN;
          else if (i__gen_cycles == '0) state_d = S_DEQ;
          else                          state_d = S_GEN;
        end
      end
      S_GEN: begin
        if (cyc_q == gen_cycles_q - COUNT_W'(1)) begin
          cyc_d = '0;
          if (deq_cycles_q != '0) begin
            state_d = S_DEQ;
          end else begin
            phase_d = phase_inc_c;
            state_d = (phase_inc_c == num_phases_q) ? S_DRAIN : S_GEN;
          end
        end
      end
      S_DEQ: begin
        // A zero-length DEQ window, reachable only when gen_cycles is also 0, lasts one cycle.
        if (cyc_q + COUNT_W'(1) >= deq_cycles_q) begin
          cyc_d   = '0;
          phase_d = phase_inc_c;
          if (phase_inc_c == num_phases_q) state_d = S_DRAIN;
          else if (gen_cycles_q == '0)     state_d = S_DEQ;
          else                             state_d = S_GEN;
        end
      end
      S_DRAIN: begin
        if (i__pifo_empty) begin
          cyc_d   = '0;
          state_d = S_DONE;
        end
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
        else if (cyc_q == COUNT_W'(DRAIN_TIMEOUT - 1)) begin
          cyc_d     = '0;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered decodes of the next state, so they line up with state_q.
    generate_phase_d = (state_d == S_GEN);
    busy_d           = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d           = (state_d == S_DONE);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      phase_q          <= '0;
      cyc_q            <= '0;
      num_phases_q     <= '0;
      gen_cycles_q     <= '0;
      deq_cycles_q     <= '0;
      num_enq_q        <= '0;
      num_deq_q        <= '0;
      generate_phase_q <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
      timeout_q        <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      phase_q          <= phase_d;
      cyc_q            <= cyc_d;
      num_phases_q     <= num_phases_d;
      gen_cycles_q     <= gen_cycles_d;
      deq_cycles_q     <= deq_cycles_d;
      num_enq_q        <= num_enq_d;
      num_deq_q        <= num_deq_d;
      generate_phase_q <= generate_phase_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
      timeout_q        <= timeout_d;
`endif
    end
  end

  assign o__generate_phase = generate_phase_q;
  assign o__phase_count    = phase_q;
  assign o__pifo_deq_req   = deq_req_c;
  assign o__busy           = busy_q;
  assign o__done           = done_q;
  assign o__num_enq        = num_enq_q;
  assign o__num_deq        = num_deq_q;
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
  assign o__timeout        = timeout_q;
`else
  assign o__timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller. For each run, the
// expected per-cycle window schedule is pushed onto a queue when the start
// is driven. Each entry is popped and compared as the DUT steps through
// that cycle.
module tb_traffic_phase_controller;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i__start;
  logic [W-1:0] i__num_phases, i__gen_cycles, i__deq_cycles;
  logic         i__pifo_empty, i__pkt_enq_valid;
  logic         o__generate_phase, o__pifo_deq_req, o__busy, o__done, o__timeout;
  logic [W-1:0] o__phase_count, o__num_enq, o__num_deq;

  traffic_phase_controller #(.COUNT_W(W), .DRAIN_TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .i__start(i__start),
    .i__num_phases(i__num_phases), .i__gen_cycles(i__gen_cycles),
    .i__deq_cycles(i__deq_cycles), .i__pifo_empty(i__pifo_empty),
    .i__pkt_enq_valid(i__pkt_enq_valid), .o__generate_phase(o__generate_phase),
    .o__phase_count(o__phase_count), .o__pifo_deq_req(o__pifo_deq_req),
    .o__busy(o__busy), .o__done(o__done), .o__timeout(o__timeout),
    .o__num_enq(o__num_enq), .o__num_deq(o__num_deq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         gen;
    logic [W-1:0] phase;
    logic         deqwin;
  } exp_t;
  exp_t exp_q[$];

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected window schedule: GEN cycles, then DEQ cycles, for each phase.
  task automatic push_schedule(input int np, input int g, input int d);
    exp_t e;
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < g; c++) begin
        e.gen = 1'b1; e.phase = W'(p); e.deqwin = 1'b0; exp_q.push_back(e);
      end
      for (int c = 0; c < d; c++) begin
        e.gen = 1'b0; e.phase = W'(p); e.deqwin = 1'b1; exp_q.push_back(e);
      end
    end
  endtask

  // Pulse start with the given config; junk config afterwards must be ignored.
  task automatic start_run(input int np, input int g, input int d);
    i__num_phases = W'(np);
    i__gen_cycles = W'(g);
    i__deq_cycles = W'(d);
    i__start      = 1'b1;
    #1;
    cyc();
    i__start      = 1'b0;
    i__num_phases = W'(7);
    i__gen_cycles = W'(1);
    i__deq_cycles = W'(1);
  endtask

  // Pop and check up to max_items schedule entries. The PIFO reports empty
  // once deq_budget dequeues have been served. Enqueues are driven on every
  // GEN cycle. A stray start is pulsed at item restart_at.
  task automatic play(input int deq_budget, input int restart_at, input int max_items);
    exp_t e;
    int   deqs = 0;
    int   k    = 0;
    while (exp_q.size() > 0 && k < max_items) begin
      e = exp_q.pop_front();
      i__pifo_empty    = (deqs >= deq_budget);
      i__pkt_enq_valid = e.gen;
      i__start         = (k == restart_at);
      if (k == restart_at) begin
        i__num_phases = W'(5);
        i__gen_cycles = W'(9);
      end
      #1;
      check_eq("gen_phase", W'(o__generate_phase), W'(e.gen));
      check_eq("phase_count", o__phase_count, e.phase);
      check_eq("deq_req", W'(o__pifo_deq_req), W'(e.deqwin && !i__pifo_empty));
      check_eq("busy_run", W'(o__busy), W'(1));
      if (e.deqwin && !i__pifo_empty) deqs++;
      cyc();
      i__start = 1'b0;
      k++;
    end
    i__pkt_enq_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gen"},   W'(o__generate_phase), '0);
    check_eq({tag, "_phase"}, o__phase_count, '0);
    check_eq({tag, "_deq"},   W'(o__pifo_deq_req), '0);
    check_eq({tag, "_busy"},  W'(o__busy), '0);
    check_eq({tag, "_done"},  W'(o__done), '0);
    check_eq({tag, "_tmo"},   W'(o__timeout), '0);
    check_eq({tag, "_nenq"},  o__num_enq, '0);
    check_eq({tag, "_ndeq"},  o__num_deq, '0);
  endtask

  initial begin
    reset_n          = 1'b0;
    i__start         = 1'b0;
    i__num_phases    = '0;
    i__gen_cycles    = '0;
    i__deq_cycles    = '0;
    i__pifo_empty    = 1'b1;
    i__pkt_enq_valid = 1'b0;
    #12;
    check_all_zero("reset");
    reset_n = 1'b1;
    cyc();

    // Nominal run: 2 phases, gen=4, deq=3, PIFO empties after 5 dequeues.
    i__pifo_empty = 1'b0;
    push_schedule(2, 4, 3);
    start_run(2, 4, 3);
    play(5, -1, 1000);
    i__pifo_empty = 1'b1;
    #1;
    check_eq("nom_drain_busy", W'(o__busy), W'(1));
    check_eq("nom_drain_phase", o__phase_count, W'(2));
    check_eq("nom_drain_deq", W'(o__pifo_deq_req), '0);
    check_eq("nom_drain_done", W'(o__done), '0);
    cyc();
    #1;
    check_eq("nom_done", W'(o__done), W'(1));
    check_eq("nom_busy", W'(o__busy), '0);
    check_eq("nom_num_enq", o__num_enq, W'(8));
    check_eq("nom_num_deq", o__num_deq, W'(5));
    check_eq("nom_phase", o__phase_count, W'(2));
    check_eq("nom_tmo", W'(o__timeout), '0);

    // Zero-phase run straight into DRAIN; empty PIFO gives done two cycles after start.
    start_run(0, 5, 5);
    #1;
    check_eq("zp_busy", W'(o__busy), W'(1));
    check_eq("zp_gen", W'(o__generate_phase), '0);
    check_eq("zp_done0", W'(o__done), '0);
    check_eq("zp_num_enq_clr", o__num_enq, '0);
    check_eq("zp_num_deq_clr", o__num_deq, '0);
    cyc();
    #1;
    check_eq("zp_done", W'(o__done), W'(1));
    check_eq("zp_busy_done", W'(o__busy), '0);
    check_eq("zp_phase", o__phase_count, '0);

    // gen_cycles=0: three phases of two DEQ cycles, then DRAIN for 3 cycles.
    i__pifo_empty = 1'b0;
    push_schedule(3, 0, 2);
    start_run(3, 0, 2);
    play(1000, -1, 1000);
    #1;
    check_eq("g0_num_deq", o__num_deq, W'(6));
    check_eq("g0_phase", o__phase_count, W'(3));
    for (int i = 0; i < 3; i++) begin
      check_eq("g0_drain_req", W'(o__pifo_deq_req), W'(1));
      check_eq("g0_drain_busy", W'(o__busy), W'(1));
      cyc();
      #1;
    end
    i__pifo_empty = 1'b1;
    #1;
    check_eq("g0_empty_req", W'(o__pifo_deq_req), '0);
    cyc();
    #1;
    check_eq("g0_done", W'(o__done), W'(1));
    check_eq("g0_num_deq_fin", o__num_deq, W'(9));
    check_eq("g0_num_enq", o__num_enq, '0);

    // A start pulse during GEN of phase 0 must be ignored.
    i__pifo_empty = 1'b0;
    push_schedule(1, 4, 2);
    start_run(1, 4, 2);
    play(2, 1, 1000);
    i__pifo_empty = 1'b1;
    #1;
    check_eq("rs_num_enq", o__num_enq, W'(4));
    check_eq("rs_num_deq", o__num_deq, W'(2));
    check_eq("rs_phase", o__phase_count, W'(1));
    cyc();
    #1;
    check_eq("rs_done", W'(o__done), W'(1));

    // Asynchronous reset in the middle of a DEQ window.
    i__pifo_empty = 1'b0;
    push_schedule(2, 2, 3);
    start_run(2, 2, 3);
    play(1000, -1, 3);
    i__pifo_empty = 1'b0;
    #1;
    check_eq("ar_pre_deq", W'(o__pifo_deq_req), W'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("areset");
    exp_q.delete();
    #3;
    reset_n = 1'b1;
    cyc();
    #1;
    check_eq("ar_idle_busy", W'(o__busy), '0);
    check_eq("ar_idle_done", W'(o__done), '0);
    check_eq("ar_idle_deq", W'(o__pifo_deq_req), '0);

    // Drain with a PIFO that never empties.
    i__pifo_empty = 1'b0;
    start_run(0, 0, 0);
`ifdef TRAFFIC_PHASE_CONTROLLER_DRAIN_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      #1;
      check_eq("to_drain_req", W'(o__pifo_deq_req), W'(1));
      check_eq("to_drain_done", W'(o__done), '0);
      cyc();
    end
    #1;
    check_eq("to_done", W'(o__done), W'(1));
    check_eq("to_timeout", W'(o__timeout), W'(1));
    check_eq("to_num_deq", o__num_deq, W'(16));
    cyc();
    #1;
    check_eq("to_sticky", W'(o__timeout), W'(1));
`else
    for (int i = 0; i < 40; i++) cyc();
    #1;
    check_eq("nto_done", W'(o__done), '0);
    check_eq("nto_busy", W'(o__busy), W'(1));
    check_eq("nto_timeout", W'(o__timeout), '0);
    check_eq("nto_num_deq", o__num_deq, W'(40));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
